// File: rtl/vga_pkg.sv
// Shared VGA drawing types: screen geometry, coordinate widths
// and the drawing-stage state enum used by circle/fill/Reuleaux.
package vga_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int COLOUR_W = 3;

    // Offsets, decision variable and signed point widths
    localparam int OFF_W  = 9;
    localparam int CRIT_W = 11;
    localparam int PT_W   = 10;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        INIT   = 4'd1,
        PLOT0  = 4'd2,
        PLOT1  = 4'd3,
        PLOT2  = 4'd4,
        PLOT3  = 4'd5,
        PLOT4  = 4'd6,
        PLOT5  = 4'd7,
        PLOT6  = 4'd8,
        PLOT7  = 4'd9,
        UPDATE = 4'd10,
        DONE   = 4'd11
    } draw_state_t;

endpackage

// File: rtl/octant_point.sv
// Combinational octant mirror: point k of (cx,cy) +/- (ox,oy).
// Ports: i_k, i_cx, i_cy, i_ox, i_oy in; o_px, o_py, o_on_screen out.
module octant_point
    import vga_pkg::*;
#(
    parameter int SCR_W = vga_pkg::SCREEN_W,
    parameter int SCR_H = vga_pkg::SCREEN_H
) (
    input  logic [2:0]              i_k,
    input  logic [X_W-1:0]          i_cx,
    input  logic [Y_W-1:0]          i_cy,
    input  logic signed [OFF_W-1:0] i_ox,
    input  logic signed [OFF_W-1:0] i_oy,
    output logic signed [PT_W-1:0]  o_px,
    output logic signed [PT_W-1:0]  o_py,
    output logic                    o_on_screen
);

    localparam logic signed [PT_W-1:0] XLIM = PT_W'(SCR_W);
    localparam logic signed [PT_W-1:0] YLIM = PT_W'(SCR_H);

    logic signed [PT_W-1:0] w_cx;
    logic signed [PT_W-1:0] w_cy;
    logic signed [PT_W-1:0] w_ox;
    logic signed [PT_W-1:0] w_oy;
    logic signed [PT_W-1:0] w_dx;
    logic signed [PT_W-1:0] w_dy;
    logic                   w_x_neg;
    logic                   w_y_neg;

    assign w_cx = $signed({2'b00, i_cx});
    assign w_cy = $signed({3'b000, i_cy});
    assign w_ox = {i_ox[OFF_W-1], i_ox};
    assign w_oy = {i_oy[OFF_W-1], i_oy};

    // Odd octants swap the roles of ox and oy
    assign w_dx = i_k[0] ? w_oy : w_ox;
    assign w_dy = i_k[0] ? w_ox : w_oy;

    // x is subtracted for k=2..5, y for k=4..7
    assign w_x_neg = i_k[2] ^ i_k[1];
    assign w_y_neg = i_k[2];

    assign o_px = w_x_neg ? (w_cx - w_dx) : (w_cx + w_dx);
    assign o_py = w_y_neg ? (w_cy - w_dy) : (w_cy + w_dy);

    assign o_on_screen = !o_px[PT_W-1] && (o_px < XLIM)
                      && !o_py[PT_W-1] && (o_py < YLIM);

endmodule

// File: rtl/circle_plotter.sv
// Midpoint circle outline drawer feeding the VGA adapter, one
// pixel per PLOT cycle with off-screen points clipped.
// Ports: clk, rst (async, high), start/centre_x/centre_y/radius/
// colour in; done, vga_x, vga_y, vga_colour, vga_plot out.
module circle_plotter #(
    parameter int SCREEN_W = vga_pkg::SCREEN_W,
    parameter int SCREEN_H = vga_pkg::SCREEN_H
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [vga_pkg::X_W-1:0]      centre_x,
    input  logic [vga_pkg::Y_W-1:0]      centre_y,
    input  logic [7:0]                   radius,
    input  logic [vga_pkg::COLOUR_W-1:0] colour,
    output logic                         done,
    output logic [vga_pkg::X_W-1:0]      vga_x,
    output logic [vga_pkg::Y_W-1:0]      vga_y,
    output logic [vga_pkg::COLOUR_W-1:0] vga_colour,
    output logic                         vga_plot
);

    import vga_pkg::*;

    draw_state_t r_state;
    draw_state_t w_next;

    logic [X_W-1:0]      r_cx;
    logic [Y_W-1:0]      r_cy;
    logic [7:0]          r_r;
    logic [COLOUR_W-1:0] r_colour;

    logic signed [OFF_W-1:0]  r_ox;
    logic signed [OFF_W-1:0]  r_oy;
    logic signed [CRIT_W-1:0] r_crit;

    logic [X_W-1:0] r_hold_x;
    logic [Y_W-1:0] r_hold_y;
    logic           r_done;

    logic signed [OFF_W-1:0]  w_oy_new;
    logic signed [OFF_W-1:0]  w_ox_new;
    logic signed [CRIT_W-1:0] w_oy_e;
    logic signed [CRIT_W-1:0] w_ox_e;
    logic signed [CRIT_W-1:0] w_crit_new;
    logic                     w_crit_le0;
    logic                     w_continue;

    logic                   w_in_plot;
    logic [2:0]             w_k;
    logic signed [PT_W-1:0] w_px;
    logic signed [PT_W-1:0] w_py;
    logic                   w_on;
    logic                   w_unused_hi;

    // Midpoint step
    assign w_crit_le0 = r_crit[CRIT_W-1] || (r_crit == '0);
    assign w_oy_new   = r_oy + 9'sd1;
    assign w_ox_new   = w_crit_le0 ? r_ox : (r_ox - 9'sd1);
    assign w_oy_e     = {{2{w_oy_new[OFF_W-1]}}, w_oy_new};
    assign w_ox_e     = {{2{w_ox_new[OFF_W-1]}}, w_ox_new};
    assign w_crit_new = r_crit + 11'sd1
                      + (w_crit_le0 ? (w_oy_e <<< 1)
                                    : ((w_oy_e - w_ox_e) <<< 1));
    assign w_continue = (w_oy_new <= w_ox_new);

    assign w_in_plot = (r_state >= PLOT0) && (r_state <= PLOT7);
    assign w_k       = 3'(r_state - PLOT0);

    octant_point #(
        .SCR_W(SCREEN_W),
        .SCR_H(SCREEN_H)
    ) u_oct (
        .i_k        (w_k),
        .i_cx       (r_cx),
        .i_cy       (r_cy),
        .i_ox       (r_ox),
        .i_oy       (r_oy),
        .o_px       (w_px),
        .o_py       (w_py),
        .o_on_screen(w_on)
    );

    // Only the low bits reach the adapter; clipping covers the rest
    assign w_unused_hi = ^{w_px[PT_W-1:X_W], w_py[PT_W-1:Y_W]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (start) w_next = INIT;
            INIT:    w_next = PLOT0;
            PLOT0, PLOT1, PLOT2, PLOT3,
            PLOT4, PLOT5, PLOT6:
                     w_next = draw_state_t'(r_state + 4'd1);
            PLOT7:   w_next = UPDATE;
            UPDATE:  w_next = w_continue ? PLOT0 : DONE;
            DONE:    if (!start) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cx     <= '0;
            r_cy     <= '0;
            r_r      <= '0;
            r_colour <= '0;
            r_ox     <= '0;
            r_oy     <= '0;
            r_crit   <= '0;
            r_hold_x <= '0;
            r_hold_y <= '0;
            r_done   <= 1'b0;
        end else begin
            // done follows DONE one cycle late and drops with start
            r_done <= (r_state == DONE) && start;
            if (w_in_plot) begin
                r_hold_x <= w_px[X_W-1:0];
                r_hold_y <= w_py[Y_W-1:0];
            end
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_cx     <= centre_x;
                        r_cy     <= centre_y;
                        r_r      <= radius;
                        r_colour <= colour;
                    end
                end
                INIT: begin
                    r_ox   <= $signed({1'b0, r_r});
                    r_oy   <= '0;
                    r_crit <= 11'sd1 - $signed({3'b000, r_r});
                end
                UPDATE: begin
                    r_ox   <= w_ox_new;
                    r_oy   <= w_oy_new;
                    r_crit <= w_crit_new;
                end
                default: ;
            endcase
        end
    end

    assign done       = r_done;
    assign vga_x      = w_in_plot ? w_px[X_W-1:0] : r_hold_x;
    assign vga_y      = w_in_plot ? w_py[Y_W-1:0] : r_hold_y;
    assign vga_colour = r_colour;
    assign vga_plot   = w_in_plot && w_on;

endmodule

// File: tb/tb_circle_plotter.sv
// Scoreboard bench for circle_plotter: expected pixels are queued
// by the driver and popped by a monitor on every plot strobe.
module tb_circle_plotter;

    import vga_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [7:0] centre_x = '0;
    logic [6:0] centre_y = '0;
    logic [7:0] radius = '0;
    logic [2:0] colour = '0;
    logic       done;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;

    circle_plotter dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .centre_x  (centre_x),
        .centre_y  (centre_y),
        .radius    (radius),
        .colour    (colour),
        .done      (done),
        .vga_x     (vga_x),
        .vga_y     (vga_y),
        .vga_colour(vga_colour),
        .vga_plot  (vga_plot)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [17:0] exp_q[$];
    bit seen_a = 0;
    bit seen_b = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic push(input int x, input int y, input int c);
        logic [7:0] px;
        logic [6:0] py;
        logic [2:0] pc;
        px = 8'(x);
        py = 7'(y);
        pc = 3'(c);
        exp_q.push_back({px, py, pc});
    endtask

    // Reference midpoint walk; pushes on-screen points, returns passes
    task automatic model_push(input int cx, input int cy, input int r,
                              input int c, output int n);
        int ox, oy, crit, px, py;
        ox = r;
        oy = 0;
        crit = 1 - r;
        n = 0;
        do begin
            for (int k = 0; k < 8; k++) begin
                case (k)
                    0: begin px = cx + ox; py = cy + oy; end
                    1: begin px = cx + oy; py = cy + ox; end
                    2: begin px = cx - ox; py = cy + oy; end
                    3: begin px = cx - oy; py = cy + ox; end
                    4: begin px = cx - ox; py = cy - oy; end
                    5: begin px = cx - oy; py = cy - ox; end
                    6: begin px = cx + ox; py = cy - oy; end
                    default: begin px = cx + oy; py = cy - ox; end
                endcase
                if (px >= 0 && px < 160 && py >= 0 && py < 120)
                    push(px, py, c);
            end
            n++;
            oy++;
            if (crit <= 0) crit += 2 * oy + 1;
            else begin
                ox--;
                crit += 2 * (oy - ox) + 1;
            end
        end while (oy <= ox);
    endtask

    always @(negedge clk) begin
        if (!rst && vga_plot) begin
            if (vga_x == 8'd10 && vga_y == 7'd0) seen_a = 1;
            if (vga_x == 8'd0 && vga_y == 7'd10) seen_b = 1;
            check("in_range", {30'd0, vga_x < 8'd160, vga_y < 7'd120}, 3);
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL extra_plot: got (%0d,%0d), expected none",
                         vga_x, vga_y);
            end else begin
                logic [17:0] e;
                e = exp_q.pop_front();
                if ({vga_x, vga_y, vga_colour} !== e) begin
                    n_bad++;
                    $display("FAIL pixel: got (%0d,%0d,c%0d), expected (%0d,%0d,c%0d)",
                             vga_x, vga_y, vga_colour,
                             e[17:10], e[9:3], e[2:0]);
                end
            end
        end
    end

    // Called right after a negedge; expected pixels already queued
    task automatic run_circle(input logic [7:0] cx, input logic [6:0] cy,
                              input logic [7:0] r, input logic [2:0] c,
                              input int exp_cyc, input string tag);
        int cyc;
        centre_x = cx;
        centre_y = cy;
        radius   = r;
        colour   = c;
        start    = 1'b1;
        @(posedge clk);
        cyc = 0;
        forever begin
            @(negedge clk);
            if (done) break;
            if (cyc > 5000) break;
            @(posedge clk);
            cyc++;
        end
        check({tag, "_latency"}, cyc, exp_cyc);
        repeat (3) @(negedge clk);
        check({tag, "_done_hold"}, {31'd0, done}, 1);
        check({tag, "_idle_plot"}, {31'd0, vga_plot}, 0);
        start = 1'b0;
        @(negedge clk);
        check({tag, "_done_drop"}, {31'd0, done}, 0);
        check({tag, "_q_left"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        int n;
        #1 rst = 1'b1;
        #1;
        check("rst_done", {31'd0, done}, 0);
        check("rst_plot", {31'd0, vga_plot}, 0);
        check("rst_x", {24'd0, vga_x}, 0);
        check("rst_y", {25'd0, vga_y}, 0);
        check("rst_colour", {29'd0, vga_colour}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // radius 0: eight copies of the centre
        repeat (8) push(80, 60, 3);
        run_circle(80, 60, 0, 3, 11, "r0");

        // radius 1: two passes
        push(81, 60, 6); push(80, 61, 6); push(79, 60, 6); push(80, 61, 6);
        push(79, 60, 6); push(80, 59, 6); push(81, 60, 6); push(80, 59, 6);
        push(81, 61, 6); push(81, 61, 6); push(79, 61, 6); push(79, 61, 6);
        push(79, 59, 6); push(79, 59, 6); push(81, 59, 6); push(81, 59, 6);
        run_circle(80, 60, 1, 6, 20, "r1");

        // radius 10 centred and in the corner: same 8 passes
        model_push(80, 60, 10, 2, n);
        check("r10_passes", n, 8);
        run_circle(80, 60, 10, 2, 74, "r10c");
        seen_a = 0;
        seen_b = 0;
        model_push(0, 0, 10, 7, n);
        run_circle(0, 0, 10, 7, 74, "r10z");
        check("seen_10_0", {31'd0, seen_a}, 1);
        check("seen_0_10", {31'd0, seen_b}, 1);

        // radius 255: mostly clipped, must still finish
        model_push(80, 60, 255, 5, n);
        run_circle(80, 60, 255, 5, 2 + 9 * n, "r255");

        // centre_x change mid-draw is ignored
        model_push(80, 60, 5, 4, n);
        fork
            run_circle(80, 60, 5, 4, 2 + 9 * n, "cx_hold");
            begin
                repeat (15) @(negedge clk);
                centre_x = 8'd20;
            end
        join
        model_push(20, 60, 5, 4, n);
        run_circle(20, 60, 5, 4, 2 + 9 * n, "cx_new");

        // reset in the middle of PLOT3
        model_push(80, 60, 10, 1, n);
        centre_x = 8'd80;
        centre_y = 7'd60;
        radius   = 8'd10;
        colour   = 3'd1;
        start    = 1'b1;
        @(posedge clk);
        repeat (4) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("mid_rst_done", {31'd0, done}, 0);
        check("mid_rst_plot", {31'd0, vga_plot}, 0);
        check("mid_rst_x", {24'd0, vga_x}, 0);
        check("mid_rst_y", {25'd0, vga_y}, 0);
        check("mid_rst_plots", exp_q.size(), 61);
        exp_q.delete();
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        model_push(80, 60, 10, 1, n);
        run_circle(80, 60, 10, 1, 74, "after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/circle_plotter.md
# circle_plotter

Draws a one-pixel-wide circle outline on the 160×120 VGA framebuffer using the midpoint (Bresenham) algorithm. It is the drawing stage directly upstream of the VGA adapter: it emits one pixel request per clock on the adapter's x/y/colour/plot inputs. The task4 top level sequences it three times to build the Reuleaux triangle. Off-screen pixels are clipped, so callers may pass any centre and radius.

## Interface
- SCREEN_W, 160: framebuffer width; valid x is 0..SCREEN_W-1.
- SCREEN_H, 120: framebuffer height; valid y is 0..SCREEN_H-1.
- clk  input  1  system clock (CLOCK_50 at top level)
- rst  input  1  reset, asynchronous, active-high
- start  input  1  request; level-sensitive, held high by caller until done
- centre_x  input  8  circle centre x, unsigned
- centre_y  input  7  circle centre y, unsigned
- radius  input  8  radius, unsigned, 0..255
- colour  input  3  pixel colour
- done  output  1  high when drawing is complete; held until start drops
- vga_x  output  8  pixel x to VGA adapter
- vga_y  output  7  pixel y to VGA adapter
- vga_colour  output  3  pixel colour to VGA adapter
- vga_plot  output  1  write strobe; at most one pixel per cycle

## Operation
- States: IDLE, INIT, PLOT0..PLOT7, UPDATE, DONE.
- IDLE with start=1: latch centre_x, centre_y, radius and colour, then go to INIT. Inputs are not sampled again until the next IDLE.
- INIT: ox = radius, oy = 0, crit = 1 - radius, then go to PLOT0.
- PLOTk emits octant point k, then goes to PLOTk+1. PLOT7 goes to UPDATE.
  - k=0: (cx+ox, cy+oy)
  - k=1: (cx+oy, cy+ox)
  - k=2: (cx-ox, cy+oy)
  - k=3: (cx-oy, cy+ox)
  - k=4: (cx-ox, cy-oy)
  - k=5: (cx-oy, cy-ox)
  - k=6: (cx+ox, cy-oy)
  - k=7: (cx+oy, cy-ox)
- UPDATE: oy += 1.
  - If crit <= 0: crit += 2*oy_new + 1.
  - Else: ox -= 1, then crit += 2*(oy_new - ox_new) + 1.
  - Next state is PLOT0 if oy_new <= ox_new (signed compare), otherwise DONE.
- DONE: done=1. Go to IDLE when start=0; stay in DONE while start=1.
- Arithmetic:
  - ox and oy are 9-bit signed; ox may reach -1 when radius=0.
  - crit is 11-bit signed.
  - Point coordinates are formed at 10-bit signed.
- Clipping: a point with x<0, x>=SCREEN_W, y<0 or y>=SCREEN_H still occupies its PLOT cycle, but vga_plot=0 in that cycle. Timing therefore does not depend on clipping.
- Duplicate points (octant overlap on the diagonals and axes) are emitted again, not suppressed.
- Reset at any time: state goes to IDLE and all outputs go to 0 immediately, without waiting for a clock.

## Timing
- All outputs are Moore outputs: they are driven from registered state only.
- During a PLOTk cycle, vga_x/vga_y/vga_colour carry point k and vga_plot is 1 if the point is unclipped. The adapter samples them at the closing edge.
- Outside PLOT states, vga_plot=0 and vga_x/vga_y hold their last values. After reset, vga_x=vga_y=vga_colour=0 and done=0.
- Latency: if start is sampled high at edge 0, done rises 2+9N cycles later, where N is the number of PLOT0..PLOT7 passes (1 cycle for INIT, 9 per pass, 1 for DONE entry).
- Minimum restart: one IDLE cycle after start drops.

## Structure
- Shared package vga_pkg holds:
  - SCREEN_W and SCREEN_H defaults;
  - the coordinate widths (X_W=8, Y_W=7, COLOUR_W=3);
  - the state enum shared with the fill and Reuleaux drawers.
- One sub-module, octant_point: combinational. It takes k, cx, cy, ox, oy and returns the signed point plus an on_screen flag, and is reused by the Reuleaux stage.

## Test plan
- Radius 0 at (80,60), colour 3 -> 8 plot pulses, all at (80,60) with colour 3; done rises 11 cycles after start is sampled.
- Radius 1 at (80,60) -> N=2, 16 pulses. Pass 1 plots (81,60),(80,61),(79,60),(80,61),(79,60),(80,59),(81,60),(80,59); pass 2 plots (81,61)×2,(79,61)×2,(79,59)×2,(81,59)×2. done rises at cycle 20.
- Centre (0,0), radius 10 -> no pulse with an out-of-range coordinate; (10,0) and (0,10) are plotted; cycle count equals that of the same circle centred at (80,60).
- Radius 255 at (80,60) -> run completes; every pulse lies inside 160×120; done asserts and holds while start=1, then drops one cycle after start=0.
- Assert rst during PLOT3 -> done=0 and vga_plot=0 with no clock edge needed. A new start then draws correctly from INIT.
- Change centre_x while drawing is in progress -> no effect on the current circle; the new value is used only on the next start.
